rr_grant_encoder: RTL and testbench
===================================

// Module: rr_grant_encoder
// PURPOSE
// - Round-robin arbiter for 8 requesters. Produces the registered 3-bit binary index
//   A[2:0] plus grant_valid. A[2:0] feeds the downstream 3-to-8 one-hot decoder
//   (translator). grant_valid gates the decoder's one-hot outputs.
// - Holds a grant while the winner keeps requesting.
// - Forces release after MAX_HOLD cycles, so one requester cannot starve the others.
// PARAMETERS
// - MAX_HOLD  15  max cycles a grant is held; 0 disables the timeout
// - HOLD_W    4   hold-timer width; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
// - clk          input   1  single clock, rising edge
// - rst_n        input   1  asynchronous, active-low reset
// - req          input   8  request vector, bit i = requester i; level-sensitive
// - A            output  3  granted index, registered; stable for the whole grant
// - grant_valid  output  1  high while A holds a live grant
// - release_p    output  1  1-cycle pulse: grant ended because req[A] dropped
// - timeout_p    output  1  1-cycle pulse: grant ended by the MAX_HOLD limit
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
//   Assertion takes effect immediately, without a clock edge.
// - Reset values: A=0, grant_valid=0, release_p=0, timeout_p=0, state=IDLE,
//   ptr=7, timer=0.
// - ptr holds the last granted index. The search order is ptr+1, ptr+2, ... mod 8,
//   so the first grant after reset favours requester 0.
// - FSM, 2 states:
//   - IDLE: if req!=0 at a clock edge, A<=winner, ptr<=winner, grant_valid<=1,
//     timer<=0, go to GRANT. Else stay in IDLE.
//   - GRANT: timer increments every cycle.
//     - If req[A]==0: grant_valid<=0, release_p<=1, go to IDLE.
//     - Else if MAX_HOLD!=0 and timer==MAX_HOLD-1: grant_valid<=0, timeout_p<=1,
//       go to IDLE.
//     - Else stay in GRANT.
// - Latency: req sampled at edge N gives grant_valid visible after edge N (1 cycle).
// - Grant duration: grant_valid stays high at most MAX_HOLD cycles.
// - Gap: at least one idle cycle (grant_valid=0) between consecutive grants.
//   Re-arbitration happens in IDLE on the next edge.
// - Simultaneous events:
//   - req[A] drops in the same cycle the timeout fires: release_p only,
//     timeout_p stays 0.
//   - After a timeout the search starts at ptr+1. The timed-out requester is
//     re-granted only if no other requester is pending (wrap-around to itself).
// - Other boundaries:
//   - req changes on non-granted bits during GRANT: ignored until IDLE.
//   - Wrap: ptr=7 with req[0] set gives winner 0.
// - When grant_valid=0, A keeps the last granted index (no glitching into the
//   decoder).
// - release_p and timeout_p are registered and never high in the same cycle.
// - Reset mid-grant: all outputs return to reset values asynchronously.
//   The first grant after reset favours requester 0.
// STRUCTURE
// - Shared include rr_grant_defs.vh: N_REQ=8, IDX_W=3, state encodings
//   ST_IDLE=1'b0, ST_GRANT=1'b1.
// - Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0];
//   outputs winner[2:0] and any.
//   - Implementation: rotate req right by ptr+1, priority-encode the lowest set bit,
//     add ptr+1 mod 8.
// - Top: FSM, ptr/timer/output registers, instance of rr_pick8.
// TESTING (bench instantiates rr_grant_encoder -> translator; checks D one-hot = A when valid)
// 1. Reset release, req=8'hFF
//    -> first grant A=0, D=8'h01 one cycle after the first edge.
// 2. req=8'b0000_0101, drop req[0] after 3 cycles
//    -> release_p pulse, 1 idle cycle, then A=2, grant_valid=1.
// 3. Fairness: req=8'hFF, the winner drops its bit 2 cycles into each grant
//    -> grants 0,1,2,...,7 then wrap to 0.
// 4. MAX_HOLD=4, req=8'h08 stuck
//    -> grant_valid high exactly 4 cycles, timeout_p pulse, gap, A=3 re-granted.
//    Same test with req=8'h88 -> A=3 (4 cycles), then A=7.
// 5. MAX_HOLD=4, req[A] drops on the cycle timer==3
//    -> release_p=1, timeout_p=0.
// 6. rst_n asserted low mid-grant between clock edges
//    -> grant_valid=0 and A=0 immediately; after release, req=8'h80 -> A=7.

Source files
------------

// File: rtl/rr_grant_encoder_pkg.sv
// rr_grant_encoder_pkg: shared widths and FSM encoding for the round-robin grant encoder
package rr_grant_encoder_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_grant_encoder_if.sv
// rr_grant_encoder_if: request vector in, registered grant index and status pulses out
interface rr_grant_encoder_if;
    import rr_grant_encoder_pkg::*;
    logic [N_REQ-1:0] req;
    idx_t             A;
    logic             grant_valid;
    logic             release_p;
    logic             timeout_p;
    modport master (input req, output A, grant_valid, release_p, timeout_p);
    modport slave  (output req, input A, grant_valid, release_p, timeout_p);
endinterface

// File: rtl/rr_grant_encoder_pick8.sv
// rr_pick8: first set request at or after ptr+1, wrapping modulo 8
module rr_pick8
    import rr_grant_encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  idx_t             ptr_i,
    output idx_t             winner_o,
    output logic             any_o
);
    idx_t               base;
    idx_t               off;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    always_comb begin
        base = ptr_i + 1'b1;
        dbl  = {req_i, req_i} >> base;
        rot  = dbl[N_REQ-1:0];
        off  = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = idx_t'(i);
        winner_o = base + off;
        any_o    = |req_i;
    end
endmodule

// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter over 8 requesters with grant hold and MAX_HOLD timeout
module rr_grant_encoder
    import rr_grant_encoder_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input logic                clk,
    input logic                rst_n,
    rr_grant_encoder_if.master bus
);
    state_t            state_q, state_d;
    idx_t              ptr_q, ptr_d;
    idx_t              a_q, a_d;
    logic [HOLD_W-1:0] timer_q, timer_d;
    logic              gv_q, gv_d;
    logic              rel_q, rel_d;
    logic              to_q, to_d;
    idx_t              winner;
    logic              any;
    rr_pick8 u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any)
    );
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        timer_d = timer_q;
        gv_d    = gv_q;
        rel_d   = 1'b0;
        to_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (any) begin
                a_d     = winner;
                ptr_d   = winner;
                gv_d    = 1'b1;
                timer_d = '0;
                state_d = ST_GRANT;
            end
        end else begin
            timer_d = timer_q + 1'b1;
            // a dropped request wins over a coincident timeout
            if (!bus.req[a_q]) begin
                gv_d    = 1'b0;
                rel_d   = 1'b1;
                state_d = ST_IDLE;
            end else if (MAX_HOLD != 0 && timer_q == HOLD_W'(MAX_HOLD - 1)) begin
                gv_d    = 1'b0;
                to_d    = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= idx_t'(N_REQ - 1);
            a_q     <= '0;
            timer_q <= '0;
            gv_q    <= 1'b0;
            rel_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            timer_q <= timer_d;
            gv_q    <= gv_d;
            rel_q   <= rel_d;
            to_q    <= to_d;
        end
    end
    assign bus.A           = a_q;
    assign bus.grant_valid = gv_q;
    assign bus.release_p   = rel_q;
    assign bus.timeout_p   = to_q;
endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed vectors feed a scoreboard queue; a negedge monitor checks A/valid/pulses and the one-hot decode
module tb_rr_grant_encoder;
    typedef struct packed {
        logic [2:0] a;
        logic       gv;
        logic       rel;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   idx = 0;
    exp_t q[$];
    exp_t e;
    logic [7:0] d;

    rr_grant_encoder_if bus ();

    rr_grant_encoder #(.MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // downstream 3-to-8 translator gated by grant_valid
    assign d = bus.grant_valid ? (8'b1 << bus.A) : 8'h00;

    task automatic check(input string name, input exp_t x);
        exp_t act;
        logic [7:0] d_exp;
        act   = {bus.A, bus.grant_valid, bus.release_p, bus.timeout_p};
        d_exp = x.gv ? (8'b1 << x.a) : 8'h00;
        checks++;
        if (act !== x) begin
            errors++;
            $display("FAIL %s outputs: got A=%0d gv=%b rel=%b to=%b, want A=%0d gv=%b rel=%b to=%b",
                     name, act.a, act.gv, act.rel, act.to, x.a, x.gv, x.rel, x.to);
        end
        checks++;
        if (d !== d_exp) begin
            errors++;
            $display("FAIL %s decode: got D=%h, want D=%h", name, d, d_exp);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic [2:0] a, input logic gv, input logic rel, input logic to);
        @(negedge clk);
        #1;
        bus.req = r;
        q.push_back({a, gv, rel, to});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                idx++;
                check($sformatf("step%0d", idx), e);
            end
        end
    end

    initial begin
        logic [2:0] w;
        bus.req = 8'h00;
        #1;
        check("reset", '{a: 3'd0, gv: 1'b0, rel: 1'b0, to: 1'b0});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        // first grant after reset favours 0, then hold 3 cycles, release, A=2 after one idle cycle
        step(8'hFF, 3'd0, 1, 0, 0);
        step(8'h05, 3'd0, 1, 0, 0);
        step(8'h05, 3'd0, 1, 0, 0);
        step(8'h04, 3'd0, 0, 1, 0);
        step(8'h04, 3'd2, 1, 0, 0);
        step(8'h00, 3'd2, 0, 1, 0);
        step(8'h00, 3'd2, 0, 0, 0);
        // fairness with all requesting: 3..7, wrap 0..2, back to 3
        for (int k = 0; k < 9; k++) begin
            w = 3'(3 + k);
            step(8'hFF, w, 1, 0, 0);
            step(8'hFF, w, 1, 0, 0);
            step(8'hFF & ~(8'b1 << w), w, 0, 1, 0);
        end
        step(8'h00, 3'd3, 0, 0, 0);
        // stuck requester 3: four valid cycles, timeout, gap, re-grant
        step(8'h08, 3'd3, 1, 0, 0);
        step(8'h08, 3'd3, 1, 0, 0);
        step(8'h08, 3'd3, 1, 0, 0);
        step(8'h08, 3'd3, 1, 0, 0);
        step(8'h08, 3'd3, 0, 0, 1);
        step(8'h08, 3'd3, 1, 0, 0);
        // bit 7 joins mid-grant: ignored until the timeout, then it wins
        step(8'h88, 3'd3, 1, 0, 0);
        step(8'h88, 3'd3, 1, 0, 0);
        step(8'h88, 3'd3, 1, 0, 0);
        step(8'h88, 3'd3, 0, 0, 1);
        step(8'h88, 3'd7, 1, 0, 0);
        step(8'h00, 3'd7, 0, 1, 0);
        step(8'h00, 3'd7, 0, 0, 0);
        // ptr=7 wraps to 0; drop coincides with timer==3 -> release only
        step(8'h01, 3'd0, 1, 0, 0);
        step(8'h01, 3'd0, 1, 0, 0);
        step(8'h01, 3'd0, 1, 0, 0);
        step(8'h01, 3'd0, 1, 0, 0);
        step(8'h00, 3'd0, 0, 1, 0);
        step(8'h00, 3'd0, 0, 0, 0);
        // async reset in the middle of a grant to requester 1
        step(8'hFF, 3'd1, 1, 0, 0);
        step(8'hFF, 3'd1, 1, 0, 0);
        @(negedge clk);
        #3;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        #1;
        check("async_reset", '{a: 3'd0, gv: 1'b0, rel: 1'b0, to: 1'b0});
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h80, 3'd7, 1, 0, 0);
        step(8'h00, 3'd7, 0, 1, 0);
        step(8'h00, 3'd7, 0, 0, 0);
        step(8'hFF, 3'd0, 1, 0, 0);
        step(8'h00, 3'd0, 0, 1, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
